// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and field positions shared by the CP0 slice
package cp0_pkg;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam int IM_LSB   = 10;
    localparam int EXL_BIT  = 1;
    localparam int IE_BIT   = 0;
    localparam int BD_BIT   = 31;
    localparam int CODE_LSB = 2;
    // Return address for a trapping instruction: a delay-slot instruction restarts at its branch
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/m_cp0_req_gen.sv
// m_cp0_req_gen: combinational arbitration of hardware interrupts over pipelined exceptions
module m_cp0_req_gen
    import cp0_pkg::*;
#(
    parameter int HW_INT_W = 6
) (
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [HW_INT_W-1:0] im,
    input  logic                ie,
    input  logic                exl,
    input  logic [4:0]          exc_code,
    output logic                req,
    output logic                is_int,
    output logic [4:0]          code
);
    // An interrupt needs an unmasked line, IE set and no handler running; it outranks exceptions
    always_comb begin
        is_int = (|(hw_int & im)) & ie & ~exl;
        req    = is_int | ((exc_code != EXC_INT) & ~exl);
        code   = is_int ? EXC_INT : exc_code;
    end
endmodule

// File: rtl/m_cp0.sv
// m_cp0: M-stage coprocessor 0 (SR, Cause, EPC, PRId); optional BadVAddr under CP0_BADVADDR_EN
module m_cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h2021_0701,
    parameter int          HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         din,
    input  logic [31:0]         pc,
    input  logic                bd,
    input  logic [4:0]          exc_code,
    input  logic                eret,
    input  logic [HW_INT_W-1:0] hw_int,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0]         bad_vaddr,
`endif
    output logic [31:0]         dout,
    output logic [31:0]         epc_out,
    output logic                req
);
    logic [HW_INT_W-1:0] im, ip;
    logic                exl, ie, cause_bd, is_int;
    logic [4:0]          cause_code, code;
    logic [31:0]         epc, sr_val, cause_val, badv_val;

    m_cp0_req_gen #(.HW_INT_W(HW_INT_W)) u_req_gen (
        .hw_int   (hw_int),
        .im       (im),
        .ie       (ie),
        .exl      (exl),
        .exc_code (exc_code),
        .req      (req),
        .is_int   (is_int),
        .code     (code)
    );

    // Trap entry has priority over mtc0; eret clears EXL after any same-cycle SR write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            cause_bd   <= 1'b0;
            ip         <= '0;
            cause_code <= EXC_INT;
            epc        <= '0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl        <= 1'b1;
                cause_bd   <= bd;
                cause_code <= code;
                epc        <= epc_of(pc, bd);
            end else begin
                if (we && addr == REG_SR) begin
                    im  <= din[IM_LSB +: HW_INT_W];
                    exl <= din[EXL_BIT];
                    ie  <= din[IE_BIT];
                end
                if (we && addr == REG_EPC) epc <= {din[31:2], 2'b00};
                if (eret) exl <= 1'b0;
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badv;
    // Faulting address is latched only for address-error exceptions that actually trap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) badv <= '0;
        else if (req && !is_int && (code == EXC_ADEL || code == EXC_ADES)) badv <= bad_vaddr;
    end
    assign badv_val = badv;
`else
    assign badv_val = '0;
`endif

    // Assemble architectural views and select the mfc0 source from the live registers
    always_comb begin
        sr_val    = '0;
        cause_val = '0;
        sr_val[IM_LSB +: HW_INT_W]  = im;
        sr_val[EXL_BIT]             = exl;
        sr_val[IE_BIT]              = ie;
        cause_val[BD_BIT]           = cause_bd;
        cause_val[IM_LSB +: HW_INT_W] = ip;
        cause_val[CODE_LSB +: 5]    = cause_code;
        dout = addr == REG_SR       ? sr_val    :
               addr == REG_CAUSE    ? cause_val :
               addr == REG_EPC      ? epc       :
               addr == REG_PRID     ? PRID_VAL  :
               addr == REG_BADVADDR ? badv_val  : 32'd0;
        epc_out = epc;
    end
endmodule

// File: tb/tb_m_cp0.sv
// tb_m_cp0: scoreboard bench for m_cp0 with directed scenarios and randomized traffic
module tb_m_cp0;
    logic        clk = 1'b0;
    logic        reset, we, bd, eret;
    logic [4:0]  addr, exc_code;
    logic [31:0] din, pc, bad_vaddr;
    logic [5:0]  hw_int;
    logic [31:0] dout, epc_out;
    logic        req;

    m_cp0 dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .pc       (pc),
        .bd       (bd),
        .exc_code (exc_code),
        .eret     (eret),
        .hw_int   (hw_int),
`ifdef CP0_BADVADDR_EN
        .bad_vaddr(bad_vaddr),
`endif
        .dout     (dout),
        .epc_out  (epc_out),
        .req      (req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] epc;
        logic [31:0] dout;
        int          id;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, n = 0;

    // Reference state: architectural fields kept as plain values
    bit          m_ie, m_exl, m_bd;
    int unsigned m_im, m_ip, m_code;
    logic [31:0] m_epc, m_badv;

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd12:   return 32'((m_im << 10) + (m_exl ? 2 : 0) + (m_ie ? 1 : 0));
            5'd13:   return 32'((m_bd ? 32'h8000_0000 : 0) + (m_ip << 10) + (m_code << 2));
            5'd14:   return m_epc;
            5'd15:   return 32'h2021_0701;
`ifdef CP0_BADVADDR_EN
            5'd8:    return m_badv;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input bit b, input logic [4:0] e, input bit er,
                       input logic [5:0] h);
        bit ir, xr, r;
        @(negedge clk);
        reset = rst; we = w; addr = a; din = d; pc = p; bd = b;
        exc_code = e; eret = er; hw_int = h; bad_vaddr = $urandom;
        if (rst) begin
            m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0; m_badv = 0;
        end
        ir = ((32'(h) & m_im) != 0) && m_ie && !m_exl;
        xr = (e != 0) && !m_exl;
        r  = ir || xr;
        n++;
        q.push_back('{r, m_epc, m_rd(a), n});
        if (!rst) begin
            if (r) begin
                m_exl  = 1;
                m_bd   = b;
                m_code = ir ? 0 : 32'(e);
                m_epc  = (b ? p - 4 : p) & ~32'd3;
                if (!ir && (e == 4 || e == 5)) m_badv = bad_vaddr;
            end else begin
                if (w && a == 12) begin
                    m_im = (d >> 10) % 64; m_exl = d[1]; m_ie = d[0];
                end
                if (w && a == 14) m_epc = d & ~32'd3;
                if (er) m_exl = 0;
            end
            m_ip = 32'(h);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle, clear of the rising edge
    initial forever begin
        exp_t x;
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("req", x.id, 32'(req), 32'(x.req));
            chk("epc_out", x.id, epc_out, x.epc);
            chk("dout", x.id, dout, x.dout);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] regs [5] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15};
        logic [4:0] codes[5] = '{5'd4, 5'd5, 5'd10, 5'd12, 5'd1};
        reset = 1; we = 0; addr = 0; din = 0; pc = 0; bd = 0;
        exc_code = 0; eret = 0; hw_int = 0; bad_vaddr = 0;
        cyc(1, 0, 15, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 12, 32'h401, 32'h3000, 0, 0, 0, 6'h01);
        cyc(0, 0, 13, 0, 32'h3004, 0, 0, 0, 6'h01);
        cyc(0, 0, 14, 0, 32'h3008, 0, 10, 0, 6'h01);
        cyc(0, 0, 12, 0, 32'h300C, 0, 0, 1, 6'h00);
        cyc(0, 0, 13, 0, 32'h3010, 1, 12, 0, 6'h00);
        cyc(0, 1, 14, 32'h3020, 32'h3014, 0, 0, 0, 6'h01);
        cyc(0, 0, 14, 0, 32'h3018, 0, 0, 1, 6'h01);
        cyc(0, 0, 13, 0, 32'h301C, 0, 0, 0, 6'h01);
        cyc(0, 0, 12, 0, 32'h3020, 0, 0, 1, 6'h00);
        cyc(0, 1, 14, 32'h3333, 32'h3040, 0, 4, 0, 6'h00);
        cyc(0, 0, 14, 0, 32'h3044, 0, 0, 0, 6'h00);
        cyc(0, 0, 8, 0, 32'h3048, 0, 0, 0, 6'h00);
        cyc(1, 0, 14, 0, 32'h304C, 0, 0, 0, 6'h00);
        cyc(0, 0, 15, 0, 32'h3050, 0, 0, 0, 6'h00);
        for (int i = 0; i < 600; i++) begin
            bit rst, w, b, er;
            logic [4:0] a, e;
            logic [5:0] h;
            rst = ($urandom % 60) == 0;
            w   = ($urandom % 4) == 0;
            a   = ($urandom % 6 == 0) ? 5'($urandom) : regs[$urandom % 5];
            b   = 1'($urandom);
            e   = ($urandom % 5 == 0) ? codes[$urandom % 5] : 5'd0;
            er  = ($urandom % 6) == 0;
            h   = ($urandom % 3 == 0) ? 6'($urandom) : 6'd0;
            if (er && a == 12) a = 13;
            if (rst) begin e = 0; h = 0; end
            cyc(rst, w, a, $urandom, $urandom & 32'hFFFF_FFFC, b, e, er, h);
        end
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d entries left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
